servant_uart_rx: RTL and testbench
==================================

Name: servant_uart_rx

Overview:
Synthesizable UART receiver that deserializes the bit-banged serial stream the servant SoC drives on its q output. Delivers 8N1 bytes through a one-entry valid/ready holding register, with framing-error and overrun flags. Sits beside the servant core in both the simulation top and FPGA tops, clocked by wb_clk, so host-side logic and benches can consume firmware console output without a behavioural decoder.

Parameters:
clks_per_bit, 556, wb_clk cycles per UART bit (32 MHz / 57600 baud); legal range 4..65535.
sync_stages, 2, flip-flops in the i_rx synchronizer; legal range 2..3.

Ports:
wb_clk  input  1  system clock; all logic on the rising edge.
wb_rst_n  input  1  synchronous active-low reset.
i_rx  input  1  serial line from servant q; idle high; asynchronous to wb_clk.
o_data  output  8  received byte; stable while o_valid=1.
o_valid  output  1  o_data holds an unconsumed byte.
i_ready  input  1  consumer accepts o_data when o_valid&i_ready at a clock edge.
o_frame_err  output  1  sticky; stop bit sampled low.
o_overrun  output  1  sticky; byte completed while holding register still full.
o_busy  output  1  high while FSM is not IDLE.
i_clr_err  input  1  one-cycle pulse; clears both sticky flags.

Behaviour:
- Reset (wb_rst_n=0 at an edge): FSM=IDLE, bit counter=0, baud counter=0, synchronizer flops=1, o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0. Reset wins over every other event, including mid-frame; the partial byte is discarded.
- i_rx passes through sync_stages flops; rx_s denotes the synchronized value. All decisions use rx_s only.
- Baud counter: width ceil(log2(clks_per_bit)); reloads at 0 on every state entry; a "tick" occurs when it reaches its target and then it restarts at 0.
- FSM:
  IDLE: o_busy=0. On rx_s=0, go to START with counter=0.
  START: after (clks_per_bit-1)/2 cycles (mid-bit), sample rx_s. If 1, glitch: return to IDLE, no flag. If 0, go to DATA, bit index=0.
  DATA: on each tick (every clks_per_bit cycles), shift rx_s into shift register LSB-first (shift_reg <= {rx_s, shift_reg[7:1]}); after the 8th sample go to STOP.
  STOP: on tick, sample rx_s. If 1, the byte is good. If 0, set o_frame_err, discard the byte, and go to WAIT_HIGH. Good byte: if o_valid=0, or o_valid&i_ready this same cycle, load o_data, set o_valid=1. Otherwise set o_overrun and discard the new byte (the old byte is kept). Then go to IDLE.
  WAIT_HIGH: stay until rx_s=1 (break condition), then go to IDLE. o_busy=1.
- Handshake: o_valid clears on the edge where o_valid&i_ready, unless a new byte loads in the same cycle, in which case o_valid stays 1 with new data. o_data never changes while o_valid=1 and i_ready=0.
- Sticky flags: set has priority over a same-cycle i_clr_err.
- Latency: o_valid rises sync_stages + (clks_per_bit-1)/2 + 9*clks_per_bit (+/-1) cycles after the i_rx falling edge of the start bit.
- Back-to-back frames: returning to IDLE mid-stop-bit lets a start edge immediately following the stop bit be detected with no lost frame.

Test Plan:
- clks_per_bit=16: send 8'hA5 8N1 with i_ready=1 -> one o_valid pulse with o_data=8'hA5, o_frame_err=0, o_overrun=0, o_busy low after stop.
- Send 8'h00 then 8'hFF back-to-back (no idle gap), i_ready=1 -> two accepted bytes 00, FF in order, no flags.
- i_ready=0, send 8'h12 then 8'h34 -> o_data stays 8'h12, o_overrun=1. Raise i_ready -> 8'h12 consumed, o_valid=0. Pulse i_clr_err -> o_overrun=0.
- Send 8'h55 with stop bit forced low, then hold low 40 cycles -> o_frame_err=1, no o_valid, FSM waits in WAIT_HIGH. Line high, then send 8'h3C -> 8'h3C received.
- Low glitch of 4 cycles on idle line -> no o_valid, no flags, back in IDLE.
- Assert wb_rst_n=0 during data bit 4 of 8'hC3 for 1 cycle -> all outputs at reset values, no byte delivered. Next full frame 8'h81 -> received correctly.

Source files
------------

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with a valid/ready holding register and sticky error flags
module servant_uart_rx #(
  parameter int clks_per_bit = 556,
  parameter int sync_stages  = 2
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy,
  input  logic       i_clr_err
);
  localparam int CW = $clog2(clks_per_bit);
  localparam logic [CW-1:0] FULL = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] HALF = CW'((clks_per_bit - 1) / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             sh_q;
  logic [sync_stages-1:0] sync_q;
  logic                   rx_s;
  logic                   tick;
  // synchronized line and baud tick; the start state waits only to mid-bit
  always_comb begin
    rx_s = sync_q[sync_stages-1];
    tick = cnt_q == (state_q == START ? HALF : FULL);
  end
  // synchronizer, baud counter, frame FSM, holding register and sticky flags
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      sync_q      <= '1;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], i_rx};
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (i_clr_err) begin
        o_frame_err <= 1'b0;
        o_overrun   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
            o_busy  <= 1'b1;
          end
        end
        START: if (tick) begin
          if (rx_s) begin
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: if (tick) begin
          sh_q  <= {rx_s, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (tick) begin
          if (!rx_s) begin
            o_frame_err <= 1'b1;
            state_q     <= WAIT_HIGH;
          end else begin
            if (!o_valid || i_ready) begin
              o_data  <= sh_q;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        WAIT_HIGH: if (rx_s) begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: directed and random 8N1 frames checked against a frame-level model
module tb_servant_uart_rx;
  localparam int CPB = 16;
  logic       clk = 1'b0;
  logic       rst_n, rx, ready, clr;
  logic [7:0] data;
  logic       valid, fe, ov, busy;
  int         n_run = 0;
  int         n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       held = 1'b0;
  logic [7:0] held_b = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  servant_uart_rx #(.clks_per_bit(CPB), .sync_stages(2)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_frame_err(fe), .o_overrun(ov), .o_busy(busy), .i_clr_err(clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) rx_q.push_back(data);
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick_n(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(CPB);
    end
    rx = stop;
    tick_n(CPB);
  endtask
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) m_fe = 1'b1;
    else if (ready) exp_q.push_back(b);
    else if (!held) begin
      held = 1'b1;
      held_b = b;
    end else m_ov = 1'b1;
  endtask
  task automatic frame(input logic [7:0] b, input logic good);
    send_frame(b, good);
    model_frame(b, good);
  endtask
  task automatic check_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) chk({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask
  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, fe, m_fe);
    chk({tag, "_overrun"}, ov, m_ov);
  endtask
  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    clr = 1'b0;
    tick_n(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    check_flags("rst");
    rst_n = 1'b1;
    tick_n(10);
    frame(8'hA5, 1'b1);
    tick_n(4);
    check_rx("a5");
    check_flags("a5");
    chk("a5_busy", busy, 1'b0);
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    tick_n(4);
    check_rx("b2b");
    check_flags("b2b");
    ready = 1'b0;
    frame(8'h12, 1'b1);
    frame(8'h34, 1'b1);
    tick_n(4);
    chk("ovr_data", data, held_b);
    chk("ovr_valid", valid, held);
    check_flags("ovr");
    ready = 1'b1;
    if (held) exp_q.push_back(held_b);
    held = 1'b0;
    tick_n(2);
    chk("ovr_drain_valid", valid, 1'b0);
    check_rx("ovr_drain");
    clr = 1'b1;
    m_fe = 1'b0;
    m_ov = 1'b0;
    tick_n(1);
    clr = 1'b0;
    check_flags("ovr_clr");
    frame(8'h55, 1'b0);
    tick_n(40);
    check_flags("brk");
    chk("brk_busy", busy, 1'b1);
    chk("brk_valid", valid, 1'b0);
    rx = 1'b1;
    tick_n(CPB);
    chk("brk_idle", busy, 1'b0);
    frame(8'h3C, 1'b1);
    tick_n(4);
    check_rx("brk_3c");
    check_flags("brk_3c");
    clr = 1'b1;
    m_fe = 1'b0;
    tick_n(1);
    clr = 1'b0;
    check_flags("brk_clr");
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    tick_n(30);
    check_rx("glitch");
    check_flags("glitch");
    chk("glitch_busy", busy, 1'b0);
    rx = 1'b0;
    tick_n(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 8'hC3 >> i;
      tick_n(CPB);
    end
    rx = 1'b0;
    tick_n(CPB / 2);
    chk("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick_n(1);
    rst_n = 1'b1;
    rx = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", valid, 1'b0);
    check_flags("midrst");
    tick_n(40);
    frame(8'h81, 1'b1);
    tick_n(4);
    check_rx("after_rst");
    for (int k = 0; k < 20; k++) begin
      frame(8'($urandom_range(0, 255)), 1'b1);
      tick_n($urandom_range(0, 20));
    end
    tick_n(4);
    check_rx("random");
    check_flags("random");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
